// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and constants for the 5x7 matrix scan controller
package matrix_pkg;

  // Glyph code and one column's worth of rows (bit6 = top row)
  typedef logic [2:0] glyph_id_t;
  typedef logic [6:0] col_pattern_t;
  typedef logic [1:0] phase_t;
  typedef logic [2:0] strobe_t;

  // Three mirrored column patterns for one glyph
  typedef struct packed {
    col_pattern_t col_2;
    col_pattern_t col_1;
    col_pattern_t col_0;
  } glyph_cols_t;

  localparam glyph_id_t GLYPH_BLANK = 3'd0;
  localparam glyph_id_t GLYPH_FULL  = 3'd1;
  localparam glyph_id_t GLYPH_H     = 3'd2;
  localparam glyph_id_t GLYPH_O     = 3'd3;
  localparam glyph_id_t GLYPH_I     = 3'd4;
  localparam glyph_id_t GLYPH_T     = 3'd5;
  localparam glyph_id_t GLYPH_UP    = 3'd6;
  localparam glyph_id_t GLYPH_DOWN  = 3'd7;

  localparam int     NUM_PHASES = 3;
  localparam phase_t PHASE_FIRST = 2'd0;
  localparam phase_t PHASE_LAST  = phase_t'(NUM_PHASES - 1);

  localparam strobe_t STROBE_OFF = 3'b000;
  localparam strobe_t STROBE_PH0 = 3'b001;
  localparam strobe_t STROBE_PH1 = 3'b010;
  localparam strobe_t STROBE_PH2 = 3'b100;

  // One-hot strobe for a phase; the unused encoding stays dark
  function automatic strobe_t phase_strobe(input phase_t ph);
    strobe_t s;
    case (ph)
      2'd0:    s = STROBE_PH0;
      2'd1:    s = STROBE_PH1;
      2'd2:    s = STROBE_PH2;
      default: s = STROBE_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/matrix_glyph_rom.sv
// rtl/matrix_glyph_rom.sv - combinational glyph code to column pattern lookup
module matrix_glyph_rom
  import matrix_pkg::*;
(
  input  logic [2:0] glyph_id,
  output logic [6:0] col_2,
  output logic [6:0] col_1,
  output logic [6:0] col_0
);

  glyph_cols_t cols;

  // Pattern table: columns 0/4 share col_2, 1/3 share col_1, centre column is col_0
  always_comb begin
    cols = '0;
    case (glyph_id)
      GLYPH_BLANK: cols = '{col_2: 7'h00, col_1: 7'h00, col_0: 7'h00};
      GLYPH_FULL:  cols = '{col_2: 7'h7F, col_1: 7'h7F, col_0: 7'h7F};
      GLYPH_H:     cols = '{col_2: 7'h7F, col_1: 7'h08, col_0: 7'h08};
      GLYPH_O:     cols = '{col_2: 7'h3E, col_1: 7'h41, col_0: 7'h41};
      GLYPH_I:     cols = '{col_2: 7'h41, col_1: 7'h41, col_0: 7'h7F};
      GLYPH_T:     cols = '{col_2: 7'h40, col_1: 7'h40, col_0: 7'h7F};
      GLYPH_UP:    cols = '{col_2: 7'h10, col_1: 7'h20, col_0: 7'h7F};
      GLYPH_DOWN:  cols = '{col_2: 7'h04, col_1: 7'h02, col_0: 7'h7F};
      default:     cols = '0;
    endcase
  end

  assign col_2 = cols.col_2;
  assign col_1 = cols.col_1;
  assign col_0 = cols.col_0;

endmodule

// File: rtl/matrix_scan_controller.sv
// rtl/matrix_scan_controller.sv - column strobe sequencer with double-buffered glyph requests
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int TICK_W      = 16,
  parameter int PHASE_TICKS = 16666,
  parameter int BLANK_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       glyph_valid,
  input  logic [2:0] glyph_id,
  output logic       glyph_ready,
  output logic [2:0] ring_counter,
  output logic [6:0] col_2,
  output logic [6:0] col_1,
  output logic [6:0] col_0,
  output logic       frame_done
);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(PHASE_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_TICKS);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);

  logic [TICK_W-1:0] tick_q, tick_d;
  phase_t            phase_q, phase_d;
  strobe_t           ring_q, ring_d;
  logic              frame_done_q, frame_done_d;

  glyph_id_t         active_id_q, active_id_d;
  glyph_id_t         pending_id_q, pending_id_d;
  logic              pending_full_q, pending_full_d;
  logic              glyph_ready_q, glyph_ready_d;

  col_pattern_t      col_2_q, col_2_d;
  col_pattern_t      col_1_q, col_1_d;
  col_pattern_t      col_0_q, col_0_d;
  col_pattern_t      rom_col_2, rom_col_1, rom_col_0;

  logic              frame_boundary;
  logic              in_blank;
  logic              accept;
  logic              promote;

  // Last tick of the last phase: the only point where a new glyph may take over
  assign frame_boundary = enable && (tick_q == TICK_LAST) && (phase_q == PHASE_LAST);
  assign in_blank       = (tick_q < TICK_BLANK);
  assign accept         = glyph_valid && glyph_ready_q;
  // With the scan stopped there is no frame to tear, so promote straight away
  assign promote        = pending_full_q && (frame_boundary || !enable);

  // Phase tick counter and phase sequencer; disable parks both at the start of a frame
  always_comb begin
    tick_d  = tick_q;
    phase_d = phase_q;
    if (!enable) begin
      tick_d  = '0;
      phase_d = PHASE_FIRST;
    end else if (tick_q == TICK_LAST) begin
      tick_d  = '0;
      phase_d = (phase_q == PHASE_LAST) ? PHASE_FIRST : phase_q + 2'd1;
    end else begin
      tick_d = tick_q + TICK_ONE;
    end
  end

  // Strobe and frame pulse, one clock behind the counters
  always_comb begin
    ring_d       = STROBE_OFF;
    frame_done_d = frame_boundary;
    if (enable && !in_blank) begin
      ring_d = phase_strobe(phase_q);
    end
  end

  // Pending/active glyph buffer; ready always mirrors the slot state one edge later
  always_comb begin
    active_id_d    = active_id_q;
    pending_id_d   = pending_id_q;
    pending_full_d = pending_full_q;
    if (promote) begin
      active_id_d    = pending_id_q;
      pending_full_d = 1'b0;
    end
    if (accept) begin
      pending_id_d   = glyph_id;
      pending_full_d = 1'b1;
    end
    glyph_ready_d = !pending_full_d;
  end

  matrix_glyph_rom u_rom (
    .glyph_id (active_id_q),
    .col_2    (rom_col_2),
    .col_1    (rom_col_1),
    .col_0    (rom_col_0)
  );

  // Column patterns follow the active glyph through one register stage
  always_comb begin
    col_2_d = rom_col_2;
    col_1_d = rom_col_1;
    col_0_d = rom_col_0;
  end

  // Scan timing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= '0;
      phase_q      <= PHASE_FIRST;
      ring_q       <= STROBE_OFF;
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      ring_q       <= ring_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Glyph buffer state; reset drops any request still waiting in the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_id_q    <= GLYPH_BLANK;
      pending_id_q   <= GLYPH_BLANK;
      pending_full_q <= 1'b0;
      glyph_ready_q  <= 1'b1;
    end else begin
      active_id_q    <= active_id_d;
      pending_id_q   <= pending_id_d;
      pending_full_q <= pending_full_d;
      glyph_ready_q  <= glyph_ready_d;
    end
  end

  // Registered column outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_2_q <= '0;
      col_1_q <= '0;
      col_0_q <= '0;
    end else begin
      col_2_q <= col_2_d;
      col_1_q <= col_1_d;
      col_0_q <= col_0_d;
    end
  end

  assign ring_counter = ring_q;
  assign frame_done   = frame_done_q;
  assign glyph_ready  = glyph_ready_q;
  assign col_2        = col_2_q;
  assign col_1        = col_1_q;
  assign col_0        = col_0_q;

endmodule
